// File: rtl/bit_packer_if.sv
// Field-in / word-out bundle for bit_packer. The master side drives fields; the slave side is the packer.
// A field transfers on a rising edge where input_enable && input_ready; the master holds val, size_of_bit
// and flush_bit stable until that edge. Output words have no backpressure: output_enable marks a word.
interface bit_packer_if;
    logic        input_enable;
    logic [63:0] val;
    logic [63:0] size_of_bit;
    logic        flush_bit;
    logic        input_ready;
    logic        output_enable;
    logic [31:0] output_val;
    logic [2:0]  output_bytes;
    logic        output_last;
    logic [31:0] byte_count;
    logic        size_error;
    logic        state_dbg;

    modport master (
        output input_enable, val, size_of_bit, flush_bit,
        input  input_ready, output_enable, output_val, output_bytes, output_last,
        input  byte_count, size_error, state_dbg
    );

    modport slave (
        input  input_enable, val, size_of_bit, flush_bit,
        output input_ready, output_enable, output_val, output_bytes, output_last,
        output byte_count, size_error, state_dbg
    );
endinterface

// File: rtl/bit_packer.sv
// Packs 0..64-bit fields into an MSB-first stream of 32-bit words; a flush drains and
// zero-pads the stream to a byte boundary. Valid bits sit left-justified in a 128-bit accumulator.
module bit_packer (
    input  logic       clock,
    input  logic       reset,
    bit_packer_if.slave bus
);
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [127:0] acc;
    logic [127:0] acc_next;
    logic [7:0]   cnt;
    logic [7:0]   cnt_next;

    logic         accept;
    logic         oversize;
    logic [6:0]   size;
    logic [63:0]  val_masked;
    logic [127:0] acc_drained;
    logic [7:0]   cnt_drained;
    logic [127:0] field_aligned;
    logic [7:0]   cnt_round;

    logic         emit;
    logic [31:0]  emit_val;
    logic [2:0]   emit_bytes;
    logic         emit_last;

    // Ready depends only on registered state, so upstream never sees a comb path from its own inputs.
    assign bus.input_ready = (state == ST_RUN) && (cnt <= 8'd64);
    assign bus.state_dbg   = state;

    assign accept     = bus.input_enable && bus.input_ready;
    assign oversize   = bus.size_of_bit > 64'd64;
    assign size       = oversize ? 7'd64 : bus.size_of_bit[6:0];
    assign val_masked = (size == 7'd64) ? bus.val : (bus.val & ((64'd1 << size) - 64'd1));

    assign acc_drained   = (cnt >= 8'd32) ? {acc[95:0], 32'd0} : acc;
    assign cnt_drained   = (cnt >= 8'd32) ? (cnt - 8'd32) : cnt;
    // Left-justify the field at bit 127, then slide it down past the bits still buffered.
    assign field_aligned = ({val_masked, 64'd0} << (7'd64 - size)) >> cnt_drained;
    assign cnt_round     = cnt + 8'd7;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (accept && bus.flush_bit) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (cnt <= 8'd32) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        acc_next   = acc;
        cnt_next   = cnt;
        emit       = 1'b0;
        emit_val   = 32'd0;
        emit_bytes = 3'd0;
        emit_last  = 1'b0;
        case (state)
            ST_RUN: begin
                if (cnt >= 8'd32) begin
                    emit       = 1'b1;
                    emit_val   = acc[127:96];
                    emit_bytes = 3'd4;
                end
                acc_next = acc_drained;
                cnt_next = cnt_drained;
                if (accept) begin
                    acc_next = acc_drained | field_aligned;
                    cnt_next = cnt_drained + {1'b0, size};
                end
            end
            ST_FLUSH: begin
                if (cnt > 8'd32) begin
                    emit       = 1'b1;
                    emit_val   = acc[127:96];
                    emit_bytes = 3'd4;
                    acc_next   = acc_drained;
                    cnt_next   = cnt_drained;
                end else if (cnt != 8'd0) begin
                    // Bits below the fill are already zero, so the tail word is padded for free.
                    emit       = 1'b1;
                    emit_val   = acc[127:96];
                    emit_bytes = 3'(cnt_round >> 3);
                    emit_last  = 1'b1;
                    acc_next   = 128'd0;
                    cnt_next   = 8'd0;
                end
            end
            default: begin
                acc_next = 128'd0;
                cnt_next = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc               <= 128'd0;
            cnt               <= 8'd0;
            bus.output_enable <= 1'b0;
            bus.output_val    <= 32'd0;
            bus.output_bytes  <= 3'd0;
            bus.output_last   <= 1'b0;
            bus.byte_count    <= 32'd0;
            bus.size_error    <= 1'b0;
        end else begin
            acc               <= acc_next;
            cnt               <= cnt_next;
            bus.output_enable <= emit;
            bus.output_val    <= emit_val;
            bus.output_bytes  <= emit_bytes;
            bus.output_last   <= emit_last;
            bus.byte_count    <= bus.byte_count + 32'(emit_bytes);
            bus.size_error    <= bus.size_error | (accept && oversize);
        end
    end
endmodule
